muldiv_stall_ctrl: RTL
======================

// Module: muldiv_stall_ctrl
// PURPOSE
//   Sequences the multi-cycle multiply/divide unit in the Execute stage of the 5-stage RISC-V pipeline.
//   Holds the M-extension instruction in E while the unit iterates, and bubbles M.
//   Releases the instruction with a one-cycle result_valid strobe.
//   Stall/flush outputs are ORed with the load-use hazard stalls at the top level.
// PARAMETERS
//   MUL_LAT  3   BUSY cycles for MUL/MULH/MULHSU/MULHU (>=1)
//   DIV_LAT  33  BUSY cycles for DIV/DIVU/REM/REMU (>=1)
//   CNT_W    6   counter width; must hold max(MUL_LAT,DIV_LAT)-1
// PORTS
//   clk           in   1  rising-edge clock
//   rst_n         in   1  synchronous reset, active-low
//   start_E       in   1  valid M-extension instruction is in E
//   is_div_E      in   1  1 = divide/remainder class, 0 = multiply class
//   rd_E          in   5  destination register of the E instruction
//   kill          in   1  redirect/flush of E (branch taken, trap)
//   hold_M        in   1  downstream stall; M cannot accept this cycle
//   unit_start    out  1  one-cycle pulse; datapath latches operands into the unit
//   unit_abort    out  1  one-cycle pulse; datapath discards partial result
//   stallF        out  1  hold PC
//   stallD        out  1  hold IF/ID
//   stallE        out  1  hold ID/EX (instruction stays in E)
//   flushM        out  1  insert bubble into EX/MEM
//   result_valid  out  1  unit result is on the E result bus; E->M transfer permitted
//   busy          out  1  state != IDLE
//   rd_busy       out  5  rd of the in-flight op; 0 when idle (feeds forwarding compare)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, cnt=0, rd_q=0. All registered outputs are 0.
//   Reset mid-operation aborts without a unit_abort pulse.
//   States: IDLE, BUSY, DONE. A 2-bit encoding is used.
//   IDLE: start_E && !kill -> BUSY. In the same cycle:
//     - unit_start=1; stallF/D/E=1 (combinational, so the instruction is held this cycle)
//     - cnt <= (is_div_E ? DIV_LAT : MUL_LAT) - 1; rd_q <= rd_E
//   IDLE with start_E && kill: stay IDLE, no unit_start, no stalls.
//   BUSY: stallF/D/E=1 and flushM=1 every cycle.
//     - cnt!=0: cnt <= cnt-1.
//     - cnt==0: -> DONE.
//     - kill: -> IDLE, unit_abort=1. Stalls and flushM are still 1 that cycle.
//     - kill has priority over the cnt==0 transition.
//   DONE: result_valid=1. start_E is ignored (it refers to the same instruction).
//     - !hold_M: stalls 0, -> IDLE. The instruction advances to M at this edge.
//     - hold_M: stallF/D/E=1, stay DONE, result_valid held. flushM=0; M is stalled externally.
//     - kill in DONE: -> IDLE, no unit_abort (the result is complete and discarded by the pipeline flush).
//   Timing: start cycle + LAT BUSY cycles + 1 DONE cycle = LAT+2 cycles in E with hold_M=0.
//     Stalls are high for LAT+1 of those cycles.
//   Back-to-back ops: a second start_E seen in IDLE the cycle after DONE is accepted normally.
//     There is no idle gap beyond the pipeline advance.
//   busy = (state!=IDLE). rd_busy = busy ? rd_q : 0.
//   unit_start and unit_abort are never 1 in the same cycle.
//   result_valid and unit_start are never 1 in the same cycle.
//   Illegal state encoding -> IDLE next cycle with all outputs 0.
// TESTING
//   MUL, MUL_LAT=3: start_E=1 in cycle 0 -> unit_start @0; stalls @0..3; flushM @1..3; result_valid @4; busy cleared @5.
//   DIV, DIV_LAT=33: stalls for exactly 34 cycles; result_valid @34; rd_busy=rd_E from cycle 1 to cycle 34.
//   kill in BUSY cycle 2 of a DIV -> unit_abort=1 that cycle; IDLE next cycle; no result_valid.
//   hold_M=1 for 3 cycles in DONE -> result_valid high for 4 cycles, stalls held; advance on the first cycle hold_M=0.
//   Back-to-back MUL,MUL -> second unit_start in the cycle after the first DONE; no double-start on the first instruction.
//   rst_n=0 during BUSY -> next cycle all outputs 0 and state IDLE; start_E with kill=1 in IDLE -> no unit_start.

Source files
------------

// File: rtl/muldiv_stall_ctrl_if.sv
// Handshake bundle between the E-stage pipeline control and the
// multiply/divide stall sequencer.
interface muldiv_stall_ctrl_if;
  logic       start_E;
  logic       is_div_E;
  logic [4:0] rd_E;
  logic       kill;
  logic       hold_M;
  logic       unit_start;
  logic       unit_abort;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushM;
  logic       result_valid;
  logic       busy;
  logic [4:0] rd_busy;

  modport master (
    output start_E,
    output is_div_E,
    output rd_E,
    output kill,
    output hold_M,
    input  unit_start,
    input  unit_abort,
    input  stallF,
    input  stallD,
    input  stallE,
    input  flushM,
    input  result_valid,
    input  busy,
    input  rd_busy
  );

  modport slave (
    input  start_E,
    input  is_div_E,
    input  rd_E,
    input  kill,
    input  hold_M,
    output unit_start,
    output unit_abort,
    output stallF,
    output stallD,
    output stallE,
    output flushM,
    output result_valid,
    output busy,
    output rd_busy
  );
endinterface

// File: rtl/muldiv_stall_ctrl.sv
// Stall/flush sequencer for the iterative mul/div unit in Execute.
// Holds the M-extension op in E while the unit runs, bubbles M.
module muldiv_stall_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [4:0]       rd_q;
  logic [4:0]       rd_n;

  logic             accept;
  logic             stall;
  logic             is_busy;

  assign accept = bus.start_E && !bus.kill;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rd_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rd_q  <= rd_n;
    end
  end

  // kill outranks completion while BUSY
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = rd_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = BUSY;
          cnt_n   = bus.is_div_E ? DIV_CNT
                                 : MUL_CNT;
          rd_n    = bus.rd_E;
        end
      end
      BUSY: begin
        if (bus.kill) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      DONE: begin
        if (bus.kill || !bus.hold_M) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        rd_n    = '0;
      end
    endcase
  end

  // start_E is ignored in DONE: it is still the same op
  always_comb begin
    bus.unit_start   = 1'b0;
    bus.unit_abort   = 1'b0;
    bus.flushM       = 1'b0;
    bus.result_valid = 1'b0;
    stall            = 1'b0;
    is_busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.unit_start = accept;
        stall          = accept;
      end
      BUSY: begin
        stall          = 1'b1;
        bus.flushM     = 1'b1;
        bus.unit_abort = bus.kill;
        is_busy        = 1'b1;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        stall            = bus.hold_M;
        is_busy          = 1'b1;
      end
      default: begin
        stall   = 1'b0;
        is_busy = 1'b0;
      end
    endcase
  end

  assign bus.stallF  = stall;
  assign bus.stallD  = stall;
  assign bus.stallE  = stall;
  assign bus.busy    = is_busy;
  assign bus.rd_busy = is_busy ? rd_q : 5'd0;

endmodule
